dps_irq_arbiter: RTL and testbench

- Interrupt aggregation stage directly downstream of the DPS device blocks, such as the 64-bit timer pair.
- Collects the level IRQ_VALID/IRQ_ACK handshakes of up to 8 devices and applies a per-device enable mask.
- Selects one device with round-robin priority and presents a single numbered request to the core.
- Returns the core's acknowledge to the selected device as a one-cycle pulse.

---
 rtl/dps_irq_arbiter.sv | 121 ++++++++++++
 tb/tb_dps_irq_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dps_irq_arbiter.sv
// Round-robin interrupt aggregator: masks up to 8 device level requests, presents one
// numbered request to the core and returns the core's acknowledge as a one-cycle pulse.
module dps_irq_arbiter #(
    parameter int P_DEV_N = 4,
    parameter int P_DEV_W = 2
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic [P_DEV_N-1:0] iDEV_IRQ_VALID,
    output logic [P_DEV_N-1:0] oDEV_IRQ_ACK,
    input  logic               iMASK_VALID,
    input  logic [P_DEV_N-1:0] iMASK_DATA,
    output logic [P_DEV_N-1:0] oMASK,
    output logic               oIRQ_VALID,
    output logic [P_DEV_W-1:0] oIRQ_NUM,
    input  logic               iIRQ_ACK
);

    localparam int W1 = P_DEV_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               irq_valid_q, irq_valid_d;
    logic [P_DEV_W-1:0] irq_num_q, irq_num_d;
    logic [P_DEV_N-1:0] dev_ack_q, dev_ack_d;
    logic [P_DEV_N-1:0] mask_q, mask_d;
    logic [P_DEV_W-1:0] b_last_q, b_last_d;

    logic [P_DEV_N-1:0] cand;
    logic [P_DEV_N-1:0] rot;
    logic [P_DEV_W-1:0] slot_idx [P_DEV_N];
    logic [P_DEV_W-1:0] pick;

    // Arbitration always sees the mask as it was before any write in this cycle.
    assign cand = iDEV_IRQ_VALID & mask_q;

    // Slot gi of the rotated vector holds device (b_last + 1 + gi) mod P_DEV_N.
    for (genvar gi = 0; gi < P_DEV_N; gi++) begin : g_rot
        logic [W1-1:0] sum;
        assign sum          = {1'b0, b_last_q} + W1'(gi + 1);
        assign slot_idx[gi] = (sum > W1'(P_DEV_N - 1)) ? sum[P_DEV_W-1:0] - P_DEV_W'(P_DEV_N)
                                                       : sum[P_DEV_W-1:0];
        assign rot[gi]      = cand[slot_idx[gi]];
    end

    // Lowest rotated slot wins; slot_idx maps it back to a device number.
    always_comb begin
        pick = '0;
        for (int k = P_DEV_N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick = slot_idx[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_num_d   = irq_num_q;
        dev_ack_d   = '0;
        b_last_d    = b_last_q;
        mask_d      = iMASK_VALID ? iMASK_DATA : mask_q;

        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    irq_num_d   = pick;
                    irq_valid_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once latched, the request is kept even if the device drops or is masked.
                if (iIRQ_ACK) begin
                    irq_valid_d = 1'b0;
                    dev_ack_d   = P_DEV_N'(1) << irq_num_q;
                    b_last_d    = irq_num_q;
                    state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                irq_valid_d = 1'b0;
                irq_num_d   = '0;
                dev_ack_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            irq_valid_q <= 1'b0;
            irq_num_q   <= '0;
            dev_ack_q   <= '0;
            mask_q      <= '1;
            b_last_q    <= P_DEV_W'(P_DEV_N - 1);
        end else begin
            state_q     <= state_d;
            irq_valid_q <= irq_valid_d;
            irq_num_q   <= irq_num_d;
            dev_ack_q   <= dev_ack_d;
            mask_q      <= mask_d;
            b_last_q    <= b_last_d;
        end
    end

    assign oDEV_IRQ_ACK = dev_ack_q;
    assign oMASK        = mask_q;
    assign oIRQ_VALID   = irq_valid_q;
    assign oIRQ_NUM     = irq_num_q;

endmodule

// File: tb/tb_dps_irq_arbiter.sv
// Bench for dps_irq_arbiter: directed handshake scenarios plus random traffic against a
// grant-level reference model; a 3-device instance covers the odd-size wrap-around.
module tb_dps_irq_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic inRESET = 1'b0;
    always #5 clk = ~clk;

    // 4-device instance
    logic [N-1:0] v4 = '0, md4 = '0, dack4, mask4;
    logic         mv4 = 1'b0, ack4 = 1'b0, irqv4;
    logic [1:0]   num4;

    // 3-device instance
    logic [2:0] v3 = '0, md3 = '0, dack3, mask3;
    logic       mv3 = 1'b0, ack3 = 1'b0, irqv3;
    logic [1:0] num3;

    dps_irq_arbiter #(.P_DEV_N(4), .P_DEV_W(2)) u_dut4 (
        .iCLOCK(clk), .inRESET(inRESET),
        .iDEV_IRQ_VALID(v4), .oDEV_IRQ_ACK(dack4),
        .iMASK_VALID(mv4), .iMASK_DATA(md4), .oMASK(mask4),
        .oIRQ_VALID(irqv4), .oIRQ_NUM(num4), .iIRQ_ACK(ack4)
    );

    dps_irq_arbiter #(.P_DEV_N(3), .P_DEV_W(2)) u_dut3 (
        .iCLOCK(clk), .inRESET(inRESET),
        .iDEV_IRQ_VALID(v3), .oDEV_IRQ_ACK(dack3),
        .iMASK_VALID(mv3), .iMASK_DATA(md3), .oMASK(mask3),
        .oIRQ_VALID(irqv3), .oIRQ_NUM(num3), .iIRQ_ACK(ack3)
    );

    int n_pass = 0, n_total = 0, n_fail = 0;

    // Reference model: outstanding grant, pulse to deliver, and a dead cycle after each ack.
    bit         m_req;
    int         m_num, m_last, m_dead;
    bit [N-1:0] m_ackv, m_mask;

    function automatic void model_reset();
        m_req = 0; m_num = 0; m_last = N - 1; m_dead = 0; m_ackv = '0; m_mask = '1;
    endfunction

    function automatic void model_edge(bit [N-1:0] v, bit mv, bit [N-1:0] md, bit a);
        bit [N-1:0] c;
        bit found;
        int d;
        c = v & m_mask;
        found = 0;
        m_ackv = '0;
        if (m_req) begin
            if (a) begin
                m_req = 0; m_ackv[m_num] = 1'b1; m_last = m_num; m_dead = 1;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else begin
            for (int s = 1; s <= N; s++) begin
                d = (m_last + s) % N;
                if (!found && c[d]) begin
                    found = 1; m_num = d; m_req = 1;
                end
            end
        end
        if (mv) m_mask = md;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_edge(v4, mv4, md4, ack4);
        @(posedge clk); #1;
        chk({tag, ".valid"}, 32'(irqv4), 32'(m_req));
        chk({tag, ".num"},   32'(num4),  32'(m_num));
        chk({tag, ".dack"},  32'(dack4), 32'(m_ackv));
        chk({tag, ".mask"},  32'(mask4), 32'(m_mask));
    endtask

    task automatic do_reset();
        v4 = '0; ack4 = 0; mv4 = 0; md4 = '0; v3 = '0; ack3 = 0;
        inRESET = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst.valid", 32'(irqv4), 32'd0);
        chk("rst.num",   32'(num4),  32'd0);
        chk("rst.dack",  32'(dack4), 32'd0);
        chk("rst.mask",  32'(mask4), 32'hF);
        inRESET = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int grants[$];
        int exp2[6] = '{0, 1, 2, 3, 0, 1};
        int exp3[4] = '{1, 3, 1, 3};
        int exp5[4] = '{0, 2, 0, 2};
        bit prev, found3;

        // 1: single request, ack, quiet gap
        do_reset();
        v4 = 4'b0100; step("t1.req");
        chk("t1.num2", 32'(num4), 32'd2);
        ack4 = 1; step("t1.ack");
        chk("t1.dack", 32'(dack4), 32'h4);
        ack4 = 0; v4 = '0; step("t1.gap1");
        chk("t1.gap1v", 32'(irqv4), 32'd0);
        step("t1.gap2");
        chk("t1.gap2v", 32'(irqv4), 32'd0);

        // 2: fairness with everyone pending and immediate acks
        do_reset();
        v4 = 4'hF; ack4 = 1; prev = 0; grants.delete();
        for (int i = 0; i < 18; i++) begin
            step("t2");
            if (irqv4 && !prev) grants.push_back(int'(num4));
            prev = irqv4;
        end
        chk("t2.count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("t2.seq", 32'(grants[i]), 32'(exp2[i]));

        // 3: mask 1010, then mask 0 written while device 3 is being requested
        do_reset();
        mv4 = 1; md4 = 4'b1010; step("t3.mw");
        mv4 = 0; v4 = 4'hF; ack4 = 1; prev = 0; grants.delete();
        for (int i = 0; i < 12; i++) begin
            step("t3");
            if (irqv4 && !prev) grants.push_back(int'(num4));
            prev = irqv4;
        end
        chk("t3.count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("t3.seq", 32'(grants[i]), 32'(exp3[i]));
        found3 = 0;
        for (int i = 0; i < 10 && !found3; i++) begin
            step("t3.seek");
            if (irqv4 && num4 == 2'd3) found3 = 1;
        end
        chk("t3.req3", 32'(found3), 32'd1);
        ack4 = 0; mv4 = 1; md4 = 4'b0000; step("t3.m0");
        mv4 = 0;
        chk("t3.hold.v", 32'(irqv4), 32'd1);
        chk("t3.hold.n", 32'(num4), 32'd3);
        ack4 = 1; step("t3.ack");
        chk("t3.dack", 32'(dack4), 32'h8);
        ack4 = 0;
        for (int i = 0; i < 6; i++) begin
            step("t3.quiet");
            chk("t3.nogrant", 32'(irqv4), 32'd0);
        end

        // 4: device retracts while requested
        do_reset();
        v4 = 4'b0010; step("t4.req");
        v4 = '0;
        for (int i = 0; i < 3; i++) begin
            step("t4.hold");
            chk("t4.v", 32'(irqv4), 32'd1);
            chk("t4.n", 32'(num4), 32'd1);
        end
        ack4 = 1; step("t4.ack");
        chk("t4.dack", 32'(dack4), 32'h2);
        ack4 = 0; step("t4.after");

        // 5: three devices, wrap from device 2 back to 0
        do_reset();
        v3 = 3'b101; ack3 = 1; prev = 0; grants.delete();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("t5.not3", 32'(num3 == 2'd3), 32'd0);
            if (irqv3 && !prev) grants.push_back(int'(num3));
            prev = irqv3;
        end
        chk("t5.count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("t5.seq", 32'(grants[i]), 32'(exp5[i]));
        v3 = '0; ack3 = 0;

        // 6: asynchronous reset during the ack cycle
        do_reset();
        mv4 = 1; md4 = 4'b0011; step("t6.mw");
        mv4 = 0; v4 = 4'hF; ack4 = 1; step("t6.req");
        step("t6.ack");
        chk("t6.dack", 32'(dack4), 32'h1);
        #2 inRESET = 1'b0;
        model_reset();
        #1;
        chk("t6.async.dack",  32'(dack4), 32'd0);
        chk("t6.async.valid", 32'(irqv4), 32'd0);
        chk("t6.async.num",   32'(num4),  32'd0);
        chk("t6.async.mask",  32'(mask4), 32'hF);
        @(posedge clk); #1;
        inRESET = 1'b1; ack4 = 0;
        step("t6.first");
        chk("t6.first.v", 32'(irqv4), 32'd1);
        chk("t6.first.n", 32'(num4), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v4   = 4'($urandom);
            ack4 = 1'($urandom);
            mv4  = ($urandom_range(0, 7) == 0);
            md4  = 4'($urandom);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
